dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data-memory port of mips_soc between the CPU load/store path and a debug/loader master.
//  Issues at most one access per cycle and arbitrates round-robin on conflict. Read data returns after a fixed 1-cycle latency, tagged to its issuer.
//  The debug master can lock the port for short atomic sequences; a timeout bounds the lock. Sits between the core's DM interface and the memory.
// PARAMETERS
//  AW        32  address width (byte address, passed through unchanged)
//  DW        32  data width
//  LOCK_MAX  8   max consecutive cycles dbg_lock may hold the port while cpu_req is pending
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   reset, asynchronous, active-high
//  cpu_req     in   1   CPU access request; held until cpu_gnt
//  cpu_we      in   1   1=write, 0=read
//  cpu_addr    in   AW  CPU address
//  cpu_wd      in   DW  CPU write data
//  cpu_gnt     out  1   access accepted this cycle (combinational)
//  cpu_rvalid  out  1   read data valid for CPU (registered)
//  cpu_rd      out  DW  read data to CPU
//  dbg_req, dbg_we, dbg_addr, dbg_wd, dbg_gnt, dbg_rvalid, dbg_rd : same as cpu_*, for the debug master
//  dbg_lock    in   1   debug requests exclusive ownership while asserted
//  mem_en      out  1   memory access strobe
//  mem_we      out  1   memory write enable
//  mem_addr    out  AW  memory address
//  mem_wd      out  DW  memory write data
//  mem_rd      in   DW  memory read data, valid the cycle after mem_en&&!mem_we
// BEHAVIOUR
//  - Reset: all outputs 0. last_winner=DBG, so CPU wins the first tie. state=ARB, lock_cnt=0, read tag cleared.
//  - Handshake: a request is accepted in any cycle where req&&gnt. gnt never asserts without req.
//    At most one of cpu_gnt/dbg_gnt is high per cycle.
//    mem_en = cpu_gnt|dbg_gnt. mem_we/addr/wd are muxed combinationally from the winner. When idle, addr and wd drive 0.
//  - FSM ARB:
//    - only one req -> grant it.
//    - both -> grant !last_winner.
//    - last_winner updates on every grant.
//    - dbg granted with dbg_lock=1 -> LOCKED next cycle.
//  - FSM LOCKED:
//    - only dbg may be granted; cpu_gnt=0.
//    - lock_cnt increments each cycle cpu_req=1 and holds otherwise.
//    - dbg_lock=0 -> ARB next cycle, lock_cnt=0.
//    - lock_cnt==LOCK_MAX-1 with cpu_req=1 -> forced ARB, last_winner=DBG, so CPU wins the next cycle even if dbg_req and dbg_lock persist.
//    - After a forced release, re-entering LOCKED requires a fresh dbg grant with dbg_lock=1 via ARB.
//  - Read return: on a read grant, rtag<=winner and rpend<=1 for one cycle.
//    Next cycle: <owner>_rvalid=1 and <owner>_rd=mem_rd. The other port's rvalid=0 and its rd holds its last value.
//    Back-to-back reads from alternating masters pipeline at 1/cycle with no bubble.
//  - Writes produce no rvalid. Write followed by read to the same address the next cycle returns the new data (memory is write-first; the arbiter adds no forwarding).
//  - Reset mid-operation: any pending rvalid is dropped and LOCKED exits immediately. The requester must re-issue.
//  - Req dropped before gnt: legal, no side effects. Addr/wd changes while un-granted are not an error.
// STRUCTURE
//  - mips_pkg gets: typedef enum logic {REQ_CPU, REQ_DBG} req_id_t; typedef enum logic {ARB, LOCKED} arb_state_t.
//  - No sub-module: round-robin pick, lock counter and 1-deep read tag stay inline (~150 lines).
//  - mips_soc instantiates it on the DM side, with a debug master stubbed to 0 when unused.
// TESTING
//  1. Reset 5 cycles, then CPU reads 0x10 (mem holds 0xCAFEF00D) -> cpu_gnt same cycle; cpu_rvalid=1 and cpu_rd=0xCAFEF00D next cycle; dbg_rvalid=0.
//  2. Both req every cycle for 6 cycles -> grants CPU,DBG,CPU,DBG,CPU,DBG. Exactly one gnt per cycle. mem_en=1 throughout.
//  3. dbg writes 0x20<=0x1234 with dbg_lock=1, then holds lock and req; cpu_req=1 -> cpu_gnt=0 for LOCK_MAX=8 cycles, then cpu_gnt=1 on cycle 9.
//  4. Alternating reads CPU@0x0, DBG@0x4, CPU@0x8 on consecutive cycles -> rvalid pulses routed to CPU, DBG, CPU with the matching data, no gap.
//  5. Assert rst the cycle after a CPU read grant -> cpu_rvalid stays 0, all outputs 0 while rst=1. The first post-reset tie grants CPU.
//  6. CPU write 0x30<=0xA5A5A5A5 then CPU read 0x30 next cycle -> rd=0xA5A5A5A5. Assertion "never both gnt" passes for the whole run.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and the round-robin pick for the data-memory port arbiter.
package dmem_arbiter_pkg;

    typedef enum logic {REQ_CPU, REQ_DBG} req_id_t;
    typedef enum logic {ARB, LOCKED} arb_state_t;

    // On a tie the master that did not win last time gets the port.
    function automatic req_id_t rr_pick(input logic cpu, input logic dbg, input req_id_t last);
        if (cpu && dbg) return (last == REQ_DBG) ? REQ_CPU : REQ_DBG;
        else if (dbg)   return REQ_DBG;
        else            return REQ_CPU;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wd, cpu_rd;
    logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid, dbg_lock;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wd, dbg_rd;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd, mem_rd;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wd,
        input  dbg_req, dbg_we, dbg_addr, dbg_wd, dbg_lock,
        input  mem_rd,
        output cpu_gnt, cpu_rvalid, cpu_rd,
        output dbg_gnt, dbg_rvalid, dbg_rd,
        output mem_en, mem_we, mem_addr, mem_wd
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wd,
        output dbg_req, dbg_we, dbg_addr, dbg_wd, dbg_lock,
        output mem_rd,
        input  cpu_gnt, cpu_rvalid, cpu_rd,
        input  dbg_gnt, dbg_rvalid, dbg_rd,
        input  mem_en, mem_we, mem_addr, mem_wd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for the single data-memory port, with a bounded debug
// lock and a 1-deep read tag that routes the 1-cycle read return.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 8
) (
    input logic          clk,
    input logic          rst,
    dmem_arbiter_if.slave bus
);
    localparam int CW = $clog2(LOCK_MAX + 1);

    arb_state_t    state_q, state_d;
    req_id_t       last_q, last_d, win;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rpend_q, rpend_d;
    req_id_t       rtag_q, rtag_d;
    logic [DW-1:0] cpu_rd_q, dbg_rd_q;
    logic          cpu_gnt, dbg_gnt, force_rel;
    logic          cpu_rvalid, dbg_rvalid;

    assign win = rr_pick(bus.cpu_req, bus.dbg_req, last_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        cpu_gnt   = 1'b0;
        dbg_gnt   = 1'b0;
        force_rel = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ARB: begin
                    if (bus.cpu_req || bus.dbg_req) begin
                        cpu_gnt = (win == REQ_CPU);
                        dbg_gnt = (win == REQ_DBG);
                    end
                    if (dbg_gnt && bus.dbg_lock) begin
                        state_d = LOCKED;
                        cnt_d   = '0;
                    end
                end
                LOCKED: begin
                    dbg_gnt = bus.dbg_req;
                    if (!bus.dbg_lock) begin
                        state_d = ARB;
                        cnt_d   = '0;
                    end else if (bus.cpu_req) begin
                        // Starved CPU forces the port open; it then wins the next tie.
                        if (cnt_q == CW'(LOCK_MAX - 1)) begin
                            state_d   = ARB;
                            cnt_d     = '0;
                            force_rel = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = ARB;
            endcase
        end
        if (cpu_gnt)      last_d = REQ_CPU;
        else if (dbg_gnt) last_d = REQ_DBG;
        if (force_rel)    last_d = REQ_DBG;
    end

    assign rpend_d = (cpu_gnt && !bus.cpu_we) || (dbg_gnt && !bus.dbg_we);
    assign rtag_d  = dbg_gnt ? REQ_DBG : REQ_CPU;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB;
            last_q   <= REQ_DBG;
            cnt_q    <= '0;
            rpend_q  <= 1'b0;
            rtag_q   <= REQ_CPU;
            cpu_rd_q <= '0;
            dbg_rd_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rpend_q <= rpend_d;
            rtag_q  <= rtag_d;
            if (cpu_rvalid) cpu_rd_q <= bus.mem_rd;
            if (dbg_rvalid) dbg_rd_q <= bus.mem_rd;
        end
    end

    assign cpu_rvalid = rpend_q && (rtag_q == REQ_CPU);
    assign dbg_rvalid = rpend_q && (rtag_q == REQ_DBG);

    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.dbg_gnt    = dbg_gnt;
    assign bus.cpu_rvalid = cpu_rvalid;
    assign bus.dbg_rvalid = dbg_rvalid;
    // The non-owner's read data holds its last returned value.
    assign bus.cpu_rd     = cpu_rvalid ? bus.mem_rd : cpu_rd_q;
    assign bus.dbg_rd     = dbg_rvalid ? bus.mem_rd : dbg_rd_q;

    assign bus.mem_en   = cpu_gnt | dbg_gnt;
    assign bus.mem_we   = cpu_gnt ? bus.cpu_we   : (dbg_gnt ? bus.dbg_we   : 1'b0);
    assign bus.mem_addr = cpu_gnt ? bus.cpu_addr : (dbg_gnt ? bus.dbg_addr : '0);
    assign bus.mem_wd   = cpu_gnt ? bus.cpu_wd   : (dbg_gnt ? bus.dbg_wd   : '0);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a scoreboard of expected read returns,
// a write-first memory model and per-step grant checks.
module tb_dmem_arbiter;
    localparam int AW = 32, DW = 32, LOCK_MAX = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    dmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic          dbg;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t        sb[$];
    logic [31:0] mem [0:63];
    int          total = 0;
    int          bad   = 0;

    // Write-first memory, read data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wd;
        if (bus.mem_en && !bus.mem_we) bus.mem_rd <= mem[bus.mem_addr[7:2]];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Routes every read return against the scoreboard; also never-both-grant.
    always @(negedge clk) begin
        chk("one_gnt", {63'd0, bus.cpu_gnt & bus.dbg_gnt}, 64'd0);
        if (bus.cpu_rvalid || bus.dbg_rvalid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", {62'd0, bus.cpu_rvalid, bus.dbg_rvalid}, 64'd0);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                chk("rsp_owner", {62'd0, bus.cpu_rvalid, bus.dbg_rvalid}, {62'd0, ~e.dbg, e.dbg});
                chk("rsp_data", {32'd0, bus.dbg_rvalid ? bus.dbg_rd : bus.cpu_rd}, {32'd0, e.data});
            end
        end
    end

    task automatic idle();
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wd = '0;
        bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wd = '0;
        bus.dbg_lock = 0;
    endtask

    task automatic cpu(input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wd = d;
    endtask

    task automatic dbg(input logic we, input logic [31:0] a, input logic [31:0] d, input logic lk);
        bus.dbg_req = 1; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wd = d; bus.dbg_lock = lk;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic gnt_is(input string tag, input logic c, input logic d);
        chk(tag, {62'd0, bus.cpu_gnt, bus.dbg_gnt}, {62'd0, c, d});
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'h1111_1111;
        mem[1] = 32'h2222_2222;
        mem[2] = 32'h3333_3333;
        mem[4] = 32'hCAFE_F00D;
        bus.mem_rd = '0;
        idle();

        // Reset: outputs quiet, then release.
        repeat (5) @(posedge clk);
        to_neg();
        chk("rst_mem_en", {63'd0, bus.mem_en}, 64'd0);
        chk("rst_rvalid", {62'd0, bus.cpu_rvalid, bus.dbg_rvalid}, 64'd0);
        chk("rst_rd", {bus.cpu_rd, bus.dbg_rd}, 64'd0);
        chk("rst_addr", {bus.mem_addr, bus.mem_wd}, 64'd0);
        to_next();
        rst = 1'b0;

        // 1: single CPU read, 1-cycle return.
        cpu(0, 32'h10, 0);
        to_neg();
        gnt_is("t1_gnt", 1, 0);
        chk("t1_addr", {31'd0, bus.mem_en, bus.mem_addr}, {31'd0, 1'b1, 32'h10});
        sb.push_back('{dbg: 1'b0, data: 32'hCAFE_F00D});
        to_next();
        idle();
        to_neg();
        chk("t1_rvalid", {62'd0, bus.cpu_rvalid, bus.dbg_rvalid}, {62'd0, 2'b10});
        chk("t1_rd", {32'd0, bus.cpu_rd}, {32'd0, 32'hCAFE_F00D});
        to_next();

        // Lone debug read so the next tie goes to the CPU.
        dbg(0, 32'h4, 0, 0);
        to_neg();
        gnt_is("dbg_alone", 0, 1);
        sb.push_back('{dbg: 1'b1, data: 32'h2222_2222});
        to_next();

        // 2: six-cycle tie alternates starting with CPU.
        cpu(0, 32'h0, 0);
        dbg(0, 32'h4, 0, 0);
        for (int i = 0; i < 6; i++) begin
            logic c;
            c = (i % 2 == 0);
            to_neg();
            gnt_is($sformatf("t2_gnt%0d", i), c, ~c);
            chk($sformatf("t2_en%0d", i), {63'd0, bus.mem_en}, 64'd1);
            sb.push_back('{dbg: ~c, data: c ? 32'h1111_1111 : 32'h2222_2222});
            to_next();
        end
        idle();
        to_neg();
        to_next();

        // 3: locked debug writes starve the CPU for LOCK_MAX cycles.
        dbg(1, 32'h20, 32'h1234, 1);
        to_neg();
        gnt_is("t3_lock_gnt", 0, 1);
        to_next();
        cpu(0, 32'h20, 0);
        for (int i = 0; i < LOCK_MAX; i++) begin
            to_neg();
            gnt_is($sformatf("t3_locked%0d", i), 0, 1);
            to_next();
        end
        to_neg();
        gnt_is("t3_release", 1, 0);
        sb.push_back('{dbg: 1'b0, data: 32'h1234});
        to_next();
        idle();
        to_neg();
        to_next();

        // 4: alternating reads pipeline with no bubble; non-owner rd holds.
        cpu(0, 32'h0, 0);
        to_neg();
        sb.push_back('{dbg: 1'b0, data: 32'h1111_1111});
        to_next();
        idle();
        dbg(0, 32'h4, 0, 0);
        to_neg();
        sb.push_back('{dbg: 1'b1, data: 32'h2222_2222});
        chk("t4_c0", {bus.cpu_rvalid, bus.cpu_rd}, {1'b1, 32'h1111_1111});
        to_next();
        idle();
        cpu(0, 32'h8, 0);
        to_neg();
        sb.push_back('{dbg: 1'b0, data: 32'h3333_3333});
        chk("t4_d1", {bus.dbg_rvalid, bus.dbg_rd}, {1'b1, 32'h2222_2222});
        chk("t4_hold_cpu", {bus.cpu_rvalid, bus.cpu_rd}, {1'b0, 32'h1111_1111});
        to_next();
        idle();
        to_neg();
        chk("t4_c2", {bus.cpu_rvalid, bus.cpu_rd}, {1'b1, 32'h3333_3333});
        chk("t4_hold_dbg", {bus.dbg_rvalid, bus.dbg_rd}, {1'b0, 32'h2222_2222});
        to_next();

        // 5: reset right after a read grant drops the return.
        cpu(0, 32'h0, 0);
        to_neg();
        gnt_is("t5_gnt", 1, 0);
        to_next();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            to_neg();
            gnt_is("t5_rst_gnt", 0, 0);
            chk("t5_rst_out", {bus.mem_en, bus.cpu_rvalid, bus.dbg_rvalid, bus.cpu_rd},
                {3'b000, 32'd0});
            to_next();
        end
        rst = 1'b0;
        dbg(0, 32'h4, 0, 0);
        to_neg();
        gnt_is("t5_tie", 1, 0);
        sb.push_back('{dbg: 1'b0, data: 32'h1111_1111});
        to_next();
        idle();
        to_neg();
        to_next();

        // 6: write then read the same address returns the new data.
        cpu(1, 32'h30, 32'hA5A5_A5A5);
        to_neg();
        chk("t6_wr", {62'd0, bus.cpu_gnt, bus.mem_we}, {62'd0, 2'b11});
        to_next();
        cpu(0, 32'h30, 0);
        to_neg();
        gnt_is("t6_rd_gnt", 1, 0);
        sb.push_back('{dbg: 1'b0, data: 32'hA5A5_A5A5});
        to_next();
        idle();
        to_neg();
        chk("t6_rd", {bus.cpu_rvalid, bus.cpu_rd}, {1'b1, 32'hA5A5_A5A5});
        to_next();
        to_neg();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
